// File: rtl/pcm_serializer.sv
// CIC-to-PCM serializer: captures decimated words on lr_clk, rounds/scales/saturates,
// buffers them in a small FIFO and shifts them out MSB-first on an sck/ws/sd link.
//
// state    | meaning
// ST_IDLE  | no frame in progress, o_ws=0, o_sd=0
// ST_SHIFT | frame in progress, one bit per o_sck falling event
module pcm_serializer #(
    parameter int IW       = 19,
    parameter int OW       = 16,
    parameter int SHIFT    = 3,
    parameter int DEPTH    = 4,
    parameter int BCLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    lr_clk,
    input  logic [IW-1:0]           i_data,
    output logic                    o_sck,
    output logic                    o_ws,
    output logic                    o_sd,
    output logic                    o_overflow,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = $clog2(BCLK_DIV + 1);
    localparam int BW = $clog2(OW);

    localparam logic [OW-1:0]        POS_FULL = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]        NEG_FULL = ~POS_FULL;
    localparam logic signed [IW:0]   SAT_MAX  = $signed((IW+1)'(POS_FULL));
    localparam logic signed [IW:0]   SAT_MIN  = ~SAT_MAX;
    localparam logic signed [IW:0]   RND      = $signed((IW+1)'(1) << (SHIFT-1));

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Synchroniser resets high so a static-high lr_clk at reset release is not an edge.
    logic s1, s2, s3;
    logic strobe;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= lr_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign strobe = s2 & ~s3;

    logic            cap_valid;
    logic [IW-1:0]   cap_data;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= strobe;
            if (strobe) begin
                cap_data <= i_data;
            end
        end
    end

    logic signed [IW:0] sum;
    logic signed [IW:0] shr;
    logic [OW-1:0]      sample;

    always_comb begin
        sum = $signed({cap_data[IW-1], cap_data}) + RND;
        shr = sum >>> SHIFT;
        if (shr > SAT_MAX) begin
            sample = POS_FULL;
        end else if (shr < SAT_MIN) begin
            sample = NEG_FULL;
        end else begin
            sample = shr[OW-1:0];
        end
    end

    logic [OW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  count;
    logic           full, empty, push_ok, pop;
    logic [OW-1:0]  head;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok = cap_valid & (~full | pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (cap_valid & ~push_ok) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign o_level = count;

    logic [DW-1:0] div_cnt;
    logic          div_tc, fall_evt;

    assign div_tc   = (div_cnt == DW'(BCLK_DIV - 1));
    assign fall_evt = div_tc & o_sck;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            div_cnt <= '0;
            o_sck   <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            o_sck   <= ~o_sck;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    logic [0:0]     state;
    logic [BW-1:0]  bit_cnt;
    logic [OW-1:0]  shreg;
    logic           frame_done;

    assign frame_done = (state == ST_IDLE) | (bit_cnt == '0);
    assign pop        = fall_evt & ~empty & frame_done;
    assign o_sd       = shreg[OW-1];

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            o_ws    <= 1'b0;
        end else if (fall_evt) begin
            if (frame_done) begin
                if (!empty) begin
                    state   <= ST_SHIFT;
                    shreg   <= head;
                    bit_cnt <= BW'(OW - 1);
                    o_ws    <= 1'b1;
                end else begin
                    state   <= ST_IDLE;
                    shreg   <= '0;
                    o_ws    <= 1'b0;
                end
            end else begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pcm_serializer.sv
// Bench for pcm_serializer: frame-level behavioural model checked every cycle,
// serial receiver for decoded words, directed cases plus randomized captures.
module tb_pcm_serializer;

    localparam int IW       = 19;
    localparam int OW       = 16;
    localparam int SHIFT    = 3;
    localparam int DEPTH    = 4;
    localparam int BCLK_DIV = 4;
    localparam int BITP     = 2 * BCLK_DIV;
    localparam int FRAME    = OW * BITP;

    logic          clk;
    logic          i_reset;
    logic          lr_clk;
    logic [IW-1:0] i_data;
    logic          o_sck, o_ws, o_sd, o_overflow;
    logic [2:0]    o_level;

    pcm_serializer #(
        .IW(IW), .OW(OW), .SHIFT(SHIFT), .DEPTH(DEPTH), .BCLK_DIV(BCLK_DIV)
    ) dut (
        .clk(clk), .i_reset(i_reset), .lr_clk(lr_clk), .i_data(i_data),
        .o_sck(o_sck), .o_ws(o_ws), .o_sd(o_sd), .o_overflow(o_overflow),
        .o_level(o_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] scale(input logic [IW-1:0] d);
        int v;
        v = int'($signed(d));
        v = (v + (1 << (SHIFT - 1))) >>> SHIFT;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return OW'(v);
    endfunction

    // Model: edge count since reset release, pending pushes, FIFO contents, current frame.
    typedef struct { int e; logic [OW-1:0] v; } pend_t;
    pend_t          pend[$];
    logic [OW-1:0]  mq[$];
    logic [OW-1:0]  m_popped[$];
    int             k = 0;
    bit             m_active = 0;
    int             fs = 0;
    logic [OW-1:0]  cur = '0;
    bit             m_ovf = 0;

    int  cyc = 0;
    int  ws_cycles = 0, ws_rises = 0, ws_rise_cyc = -1;
    int  last_rise = -1, sck_period = 0;
    bit  prev_ws = 0, prev_sck = 0;

    always @(posedge clk) begin
        if (!i_reset) begin
            k = 0;
            mq.delete();
            pend.delete();
            m_active = 0;
            m_ovf = 0;
        end else begin
            k++;
            if (k % BITP == 0 && (!m_active || k - fs >= FRAME)) begin
                if (mq.size() > 0) begin
                    cur = mq.pop_front();
                    m_popped.push_back(cur);
                    fs = k;
                    m_active = 1;
                end else begin
                    m_active = 0;
                end
            end
            while (pend.size() > 0 && pend[0].e <= k) begin
                if (mq.size() < DEPTH) mq.push_back(pend[0].v);
                else m_ovf = 1;
                void'(pend.pop_front());
            end
        end
        #1;
        begin
            logic e_sck, e_ws, e_sd;
            logic [6:0] got, exp;
            e_sck = 1'((k / BCLK_DIV) % 2);
            e_ws  = m_active;
            e_sd  = m_active ? cur[OW - 1 - (k - fs) / BITP] : 1'b0;
            got = {o_sck, o_ws, o_sd, o_overflow, o_level};
            exp = {e_sck, e_ws, e_sd, m_ovf, 3'(mq.size())};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle %0d sck/ws/sd/ovf/level: got %b, expected %b", cyc, got, exp);
            end
        end
        cyc++;
        if (o_ws) ws_cycles++;
        if (o_ws && !prev_ws) begin
            ws_rises++;
            ws_rise_cyc = cyc;
        end
        if (!i_reset) last_rise = -1;
        else if (o_sck && !prev_sck) begin
            if (last_rise >= 0) sck_period = cyc - last_rise;
            last_rise = cyc;
        end
        prev_ws  = o_ws;
        prev_sck = o_sck;
    end

    logic [OW-1:0] rxq[$];
    logic [OW-1:0] rx_w = '0;
    int            rx_n = 0;

    always @(posedge o_sck or negedge i_reset) begin
        if (!i_reset) begin
            rx_n = 0;
            rx_w = '0;
        end else if (o_ws) begin
            rx_w = {rx_w[OW-2:0], o_sd};
            rx_n++;
            if (rx_n == OW) begin
                rxq.push_back(rx_w);
                rx_n = 0;
            end
        end
    end

    task automatic pulse(input logic [IW-1:0] d, input int hold);
        @(negedge clk) lr_clk = 1'b0;
        repeat (3) @(negedge clk);
        lr_clk = 1'b1;
        i_data = d;
        pend.push_back('{k + 4, scale(d)});
        repeat (hold) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(pend.size() == 0 && mq.size() == 0 && !m_active && !o_ws && o_level == 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic clear_counts();
        ws_cycles = 0;
        ws_rises  = 0;
        rxq.delete();
        m_popped.delete();
    endtask

    logic [IW-1:0] t3_in  [6];
    logic [OW-1:0] t3_out [6];

    initial begin
        #5_000_000;
        $display("FAIL global timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        t3_in  = '{19'h3FFFF, 19'h40000, 19'h00004, 19'h7FFFC, 19'h7FFFB, 19'h00003};
        t3_out = '{16'h7FFF, 16'h8000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000};
        i_reset = 1'b0;
        lr_clk  = 1'b0;
        i_data  = '0;

        // Reset with activity on the inputs, then release with lr_clk high.
        repeat (20) begin
            @(negedge clk);
            lr_clk = 1'($urandom);
            i_data = IW'($urandom);
        end
        chk("reset outputs", {o_sck, o_ws, o_sd, o_overflow, o_level}, 0);
        @(negedge clk) lr_clk = 1'b1;
        @(negedge clk) i_reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("no capture on high lr_clk", o_level, 0);
        @(negedge clk) lr_clk = 1'b0;
        repeat (5) @(negedge clk);

        // Single sample: level latency, frame length, bit clock period.
        clear_counts();
        pulse(19'h00010, 0);
        repeat (3) @(posedge clk);
        #1 chk("level before push", o_level, 0);
        @(posedge clk);
        #1 chk("level 2 clk after strobe", o_level, 1);
        wait_idle(400, "single idle");
        chk("single ws cycles", ws_cycles, FRAME);
        chk("single ws rises", ws_rises, 1);
        chk("sck period", sck_period, BITP);
        chk("single frame count", rxq.size(), 1);
        if (rxq.size() > 0) chk("single frame", rxq[0], 16'h0002);

        // Rounding and saturation, one frame per input.
        for (int i = 0; i < 6; i++) begin
            clear_counts();
            chk("model scale", scale(t3_in[i]), t3_out[i]);
            pulse(t3_in[i], 6);
            wait_idle(400, "scale idle");
            chk("scale frame count", rxq.size(), 1);
            if (rxq.size() > 0) chk("scale frame", rxq[0], t3_out[i]);
        end

        // Back-to-back frames keep o_ws high.
        clear_counts();
        pulse(19'h00008, 6);
        pulse(19'h00010, 6);
        pulse(19'h00018, 6);
        wait_idle(800, "b2b idle");
        chk("b2b ws cycles", ws_cycles, 3 * FRAME);
        chk("b2b ws rises", ws_rises, 1);
        chk("b2b frame count", rxq.size(), 3);
        for (int i = 0; i < 3 && i < rxq.size(); i++) chk("b2b frame", rxq[i], i + 1);

        // Overflow: 8 captures, only 1..5 survive.
        clear_counts();
        for (int i = 1; i <= 8; i++) pulse(IW'(8 * i), 6);
        chk("overflow set", o_overflow, 1);
        wait_idle(1500, "ovf idle");
        chk("ovf frame count", rxq.size(), 5);
        for (int i = 0; i < 5 && i < rxq.size(); i++) chk("ovf frame", rxq[i], i + 1);
        repeat (50) @(negedge clk);
        chk("overflow sticky", o_overflow, 1);

        // Reset during bit 7 of a frame with one more sample queued.
        clear_counts();
        ws_rise_cyc = -1;
        pulse(19'h00400, 6);
        pulse(19'h00408, 6);
        begin
            int n;
            n = 0;
            while ((ws_rise_cyc < 0 || cyc < ws_rise_cyc + 68) && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("bit7 reached in time", n < 300, 1);
        end
        chk("pre-reset ws", o_ws, 1);
        chk("pre-reset sd bit7", o_sd, 1);
        chk("pre-reset sck", o_sck, 1);
        chk("pre-reset level", o_level, 1);
        i_reset = 1'b0;
        #1;
        chk("mid reset ws", o_ws, 0);
        chk("mid reset sd", o_sd, 0);
        chk("mid reset sck", o_sck, 0);
        chk("mid reset level", o_level, 0);
        chk("mid reset ovf", o_overflow, 0);
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        repeat (5) @(negedge clk);
        clear_counts();
        pulse(19'h00010, 6);
        wait_idle(400, "post reset idle");
        chk("post reset frame count", rxq.size(), 1);
        if (rxq.size() > 0) chk("post reset frame", rxq[0], 16'h0002);
        chk("post reset ovf", o_overflow, 0);

        // Randomized captures with random spacing, some closer than one frame.
        clear_counts();
        repeat (40) pulse(IW'($urandom), int'($urandom_range(6, 200)));
        wait_idle(2000, "random idle");
        chk("random frame count", rxq.size(), m_popped.size());
        for (int i = 0; i < rxq.size() && i < m_popped.size(); i++)
            chk("random frame", rxq[i], m_popped[i]);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcm_serializer.md
Name: pcm_serializer

Overview:
- Downstream neighbour of the CIC decimator.
- Captures each decimated CIC output word on the rising edge of lr_clk, then rounds, scales and saturates it to a 16-bit PCM sample.
- Buffers samples in a small FIFO and shifts them out MSB-first on a framed serial link (o_sck/o_ws/o_sd) toward the chip pins.

Parameters:
IW, 19, width of signed CIC input word
OW, 16, width of signed output sample
SHIFT, 3, arithmetic right shift applied before saturation (>=1)
DEPTH, 4, FIFO entries (power of 2)
BCLK_DIV, 4, clk cycles per o_sck half-period

Ports:
clk  in  1  system clock; all logic on rising edge
i_reset  in  1  asynchronous, active-low reset
lr_clk  in  1  CIC output-rate clock; asynchronous to clk
i_data  in  IW  signed two's-complement CIC output, stable around lr_clk rising edge
o_sck  out  1  serial bit clock, period 2*BCLK_DIV clk cycles
o_ws  out  1  frame valid, high while sample bits are shifted
o_sd  out  1  serial data, MSB first
o_overflow  out  1  sticky: a sample was dropped because the FIFO was full
o_level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (i_reset=0, asynchronous):
  - o_sck, o_ws, o_sd, o_overflow = 0; o_level = 0; FIFO empty; divider = 0; FSM = IDLE.
  - lr_clk synchroniser flops reset to 1, so lr_clk held high at reset release causes no capture.
  - Reset asserted mid-frame aborts the frame; outputs go to 0 immediately.
- Capture:
  - lr_clk passes through a 2-flop synchroniser (s1, s2) plus delay flop s3.
  - strobe = s2 & ~s3 in cycle N; i_data is registered at the end of cycle N.
- Scale (cycle N+1):
  - sum = sign-extended i_data (IW+1 bits) + (1 << (SHIFT-1)), i.e. round-half-up.
  - Arithmetic shift right by SHIFT.
  - Saturate to OW bits: >32767 -> 0x7FFF; < -32768 -> 0x8000.
  - Result is pushed to the FIFO at the end of cycle N+1, so latency is 2 clk from strobe to o_level increment.
- FIFO:
  - Push when full: sample dropped, o_overflow set; it stays set until reset.
  - Push and pop in the same cycle while full: pop frees the slot, push is accepted, no overflow.
  - Pop only when non-empty; pop and push while empty are impossible because a pop needs prior occupancy.
  - Pointers wrap modulo DEPTH.
- Bit clock:
  - Free-running divider toggles o_sck every BCLK_DIV clk cycles, starting low after reset.
  - "Falling event" = the cycle o_sck goes 1->0.
  - o_sd and o_ws change only on falling events; the receiver samples on o_sck rising.
- FSM:
  - IDLE: o_ws=0, o_sd=0. On a falling event with FIFO non-empty: pop the head into the shift register and go to SHIFT. o_ws=1 and o_sd=MSB at that same event.
  - SHIFT: a bit counter counts OW bits; each falling event shifts out the next bit.
  - After bit 0's period, at the next falling event:
    - FIFO non-empty: pop and start the next frame immediately. o_ws stays 1 (back-to-back frames).
    - FIFO empty: o_ws=0, o_sd=0, return to IDLE.
- Throughput: one frame = OW*2*BCLK_DIV = 128 clk at defaults. The lr_clk period must exceed this for lossless operation; otherwise overflow behaviour applies.
- o_level reflects occupancy registered after each push/pop.

Test Plan:
1. Reset:
   - Hold i_reset=0 with random lr_clk/i_data -> all outputs 0.
   - Release i_reset with lr_clk=1 -> no capture, o_level stays 0 for 200 clk.
2. Single sample:
   - Stimulus: one lr_clk rise with i_data=0x00010.
   - Required: o_level goes to 1 two clk after the strobe.
   - Frame: 16 bits 0x0002 MSB first; o_ws high exactly 16 o_sck periods (128 clk); o_sck period 8 clk; then o_ws=0, o_level=0.
3. Rounding/saturation (one captured sample per input, check each frame):
   - 0x3FFFF -> 0x7FFF
   - 0x40000 -> 0x8000
   - 0x00004 -> 0x0001
   - 0x7FFFC -> 0x0000
   - 0x7FFFB -> 0xFFFF
   - 0x00003 -> 0x0000
4. Back-to-back:
   - Stimulus: three captures 10 clk apart, values 0x00008, 0x00010, 0x00018.
   - Required: o_ws high continuously for 48 bit periods, frames 0x0001, 0x0002, 0x0003 in order, then o_ws low.
5. Overflow:
   - Stimulus: 8 lr_clk rises 10 clk apart with distinct values.
   - Required: first frame pops sample 1, FIFO holds samples 2-5, samples 6-8 dropped, o_overflow=1.
   - Output frames are samples 1-5 in order; o_overflow remains 1 after drain until reset.
6. Mid-frame reset:
   - Stimulus: assert i_reset=0 during bit 7 of a frame.
   - Required: o_ws/o_sd/o_sck=0 the same cycle, FIFO empty, o_overflow=0.
   - After release, a new capture produces a complete, correct frame.
